// File: rtl/led_deserializer_pkg.sv
// Shared WS2812 timing, decoder state encoding and GRB pixel layout,
// common to the LED serializer and deserializer.
package led_deserializer_pkg;

    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int TBIT   = 63;
    localparam int TRESET = 2500;

    localparam int BITS_PER_PIXEL = 24;
    localparam int G_OFS = 16;
    localparam int R_OFS = 8;
    localparam int B_OFS = 0;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } deser_state_e;

    function automatic logic [7:0] grb_field(input logic [BITS_PER_PIXEL-1:0] px,
                                             input int ofs);
        return px[ofs +: 8];
    endfunction

endpackage

// File: rtl/led_deserializer_if.sv
// Pixel-side bundle of the LED deserializer: serial line in, decoded pixel
// and frame status out. The slave modport is the decoder side.
interface led_deserializer_if #(
    parameter int CNT_W = 16
);
    logic             i;
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;
    logic             oVALID;
    logic [CNT_W-1:0] oLED;
    logic             oDONE;
    logic             oERR;

    modport master (output i, input r, g, b, oVALID, oLED, oDONE, oERR);
    modport slave  (input i, output r, g, b, oVALID, oLED, oDONE, oERR);
endinterface

// File: rtl/led_deserializer_line_sync.sv
// Two-flop synchronizer for the asynchronous LED line, with single-cycle
// rise/fall pulses taken against the previous synchronized level.
module led_deserializer_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            prev_q <= sync_q[1];
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/led_deserializer.sv
// WS2812 one-wire stream decoder: pulse-width bit slicing, GRB assembly,
// frame-end and error reporting. Define LED_DESER_GLITCH_EN to drop short spikes.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_SYNC | waiting for a full reset-length low before trusting the line
// ST_LOW  | line low: counting gap / frame reset time
// ST_HIGH | line high: measuring the bit's high time
module led_deserializer
    import led_deserializer_pkg::*;
#(
    parameter int THRESH    = (T0H + T1H) / 2,
    parameter int MAX_HIGH  = 60,
    parameter int RESET_CYC = TRESET,
    parameter int MIN_HIGH  = 5,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    led_deserializer_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [4:0]       LAST_BIT = 5'(BITS_PER_PIXEL - 1);
`ifdef LED_DESER_GLITCH_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    deser_state_e              state_q, state_d;
    logic [CNT_W-1:0]          high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]          low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0]          pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]          led_q, led_d;
    logic [4:0]                bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic [BITS_PER_PIXEL-1:0] pixel_q, pixel_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic                      line_lvl, line_rise, line_fall;
    logic                      bit_val;
    logic                      glitch;
    logic [BITS_PER_PIXEL-1:0] shift_nx;

    led_deserializer_line_sync u_line_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (bus.i),
        .level_o (line_lvl),
        .rise_o  (line_rise),
        .fall_o  (line_fall)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE_C;
    endfunction

    assign bit_val  = (high_cnt_q >= THRESH_C);
    assign glitch   = GLITCH_EN && (high_cnt_q < MIN_C);
    assign shift_nx = {shift_q[BITS_PER_PIXEL-2:0], bit_val};

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        led_d      = led_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pixel_d    = pixel_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            ST_SYNC: begin
                if (line_lvl) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == RESET_C) begin
                    // Step past RESET_C so entering LOW is not taken as a frame end.
                    state_d   = ST_LOW;
                    low_cnt_d = sat_inc(low_cnt_q);
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                end else begin
                    low_cnt_d = sat_inc(low_cnt_q);
                end
            end
            ST_LOW: begin
                if (low_cnt_q == RESET_C) begin
                    if (bit_cnt_q != '0) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = (pix_cnt_q != '0);
                        err_d  = 1'b0;
                    end
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                end
                if (line_rise) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = ONE_C;
                end else begin
                    low_cnt_d = sat_inc(low_cnt_q);
                end
            end
            ST_HIGH: begin
                if (high_cnt_q > MAX_C) begin
                    state_d   = ST_SYNC;
                    err_d     = 1'b1;
                    low_cnt_d = '0;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                end else if (line_fall) begin
                    state_d = ST_LOW;
                    if (glitch) begin
                        // Low count was frozen during the spike; carry on from it.
                        low_cnt_d = sat_inc(low_cnt_q);
                    end else begin
                        low_cnt_d = ONE_C;
                        shift_d   = shift_nx;
                        if (bit_cnt_q == LAST_BIT) begin
                            pixel_d   = shift_nx;
                            led_d     = pix_cnt_q;
                            valid_d   = 1'b1;
                            pix_cnt_d = pix_cnt_q + ONE_C;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else begin
                    high_cnt_d = sat_inc(high_cnt_q);
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SYNC;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            led_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            pixel_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            led_q      <= led_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.r      = grb_field(pixel_q, R_OFS);
    assign bus.g      = grb_field(pixel_q, G_OFS);
    assign bus.b      = grb_field(pixel_q, B_OFS);
    assign bus.oLED   = led_q;
    assign bus.oVALID = valid_q;
    assign bus.oDONE  = done_q;
    assign bus.oERR   = err_q;

endmodule

// File: tb/tb_led_deserializer.sv
// Self-checking bench for led_deserializer: table-driven single pixels,
// hand-built corner sequences and random frames against a pulse-list model.
module tb_led_deserializer;
    import led_deserializer_pkg::*;

    localparam int CNT_W    = 16;
    localparam int THRESH   = 30;
    localparam int MAX_HIGH = 60;
    localparam int MIN_HIGH = 5;
    localparam int RST_LO   = 2520;
    localparam int SYNC_LO  = 2600;
`ifdef LED_DESER_GLITCH_EN
    localparam bit          GLITCH_ON = 1'b1;
    localparam logic [23:0] SPIKE_PX  = 24'hA5A5A5;
`else
    localparam bit          GLITCH_ON = 1'b0;
    localparam logic [23:0] SPIKE_PX  = 24'hA552D2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    led_deserializer_if #(.CNT_W(CNT_W)) bus ();

    led_deserializer #(
        .THRESH    (THRESH),
        .MAX_HIGH  (MAX_HIGH),
        .RESET_CYC (TRESET),
        .MIN_HIGH  (MIN_HIGH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int last_lat = -1;
    int done_cnt = 0;
    int overlap_cnt = 0;
    logic [39:0] got_q[$];
    int hi_q[$];
    int lo_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.oVALID) begin
            got_q.push_back({bus.g, bus.r, bus.b, bus.oLED});
            last_lat = cyc - fall_cyc;
        end
        if (bus.oDONE) done_cnt++;
        if (bus.oVALID && bus.oDONE) overlap_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Hold the line at v for n clock periods, changing it on the falling edge.
    task automatic drive(input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0 && bus.i && !v) fall_cyc = cyc;
            bus.i = v;
        end
    endtask

    task automatic clear_frame();
        hi_q.delete();
        lo_q.delete();
    endtask

    task automatic add_bits(input logic [23:0] v, input int n, input int h0, input int h1);
        for (int k = 0; k < n; k++) begin
            int h;
            h = v[23-k] ? h1 : h0;
            hi_q.push_back(h);
            lo_q.push_back(TBIT - h);
        end
    endtask

    task automatic play(input int tail);
        got_q.delete();
        done_cnt = 0;
        foreach (hi_q[k]) begin
            drive(1'b1, hi_q[k]);
            drive(1'b0, lo_q[k]);
        end
        drive(1'b0, tail);
    endtask

    // Reference: slice each pulse by width, group into 24-bit GRB words.
    task automatic check_frame(input string name);
        logic [23:0] acc;
        logic [39:0] exp_q[$];
        int nb;
        int npx;
        acc = '0;
        nb  = 0;
        npx = 0;
        foreach (hi_q[k]) begin
            if (GLITCH_ON && hi_q[k] < MIN_HIGH) continue;
            acc = {acc[22:0], (hi_q[k] >= THRESH) ? 1'b1 : 1'b0};
            nb++;
            if (nb == 24) begin
                exp_q.push_back({acc, 16'(npx)});
                npx++;
                nb = 0;
            end
        end
        check({name, " n_valid"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s px%0d", name, k), got_q[k], exp_q[k]);
        check({name, " done"}, done_cnt, (nb == 0 && npx > 0) ? 1 : 0);
        check({name, " err"}, bus.oERR, (nb != 0) ? 1 : 0);
    endtask

    typedef struct packed {
        logic [23:0] grb;
        logic [7:0]  er;
        logic [7:0]  eg;
        logic [7:0]  eb;
    } vec_t;

    vec_t tbl[3];
    int   nbits;
    int   bv;
    int   h;

    initial begin
        tbl[0] = '{grb: 24'h123456, er: 8'h34, eg: 8'h12, eb: 8'h56};
        tbl[1] = '{grb: 24'hFF00A5, er: 8'h00, eg: 8'hFF, eb: 8'hA5};
        tbl[2] = '{grb: 24'h0180FE, er: 8'h80, eg: 8'h01, eb: 8'hFE};

        bus.i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst r", bus.r, 0);
        check("rst g", bus.g, 0);
        check("rst b", bus.b, 0);
        check("rst valid", bus.oVALID, 0);
        check("rst led", bus.oLED, 0);
        check("rst done", bus.oDONE, 0);
        check("rst err", bus.oERR, 0);
        rst_n = 1'b1;
        drive(1'b0, SYNC_LO);

        for (int v = 0; v < 3; v++) begin
            clear_frame();
            add_bits(tbl[v].grb, 24, T0H, T1H);
            play(RST_LO);
            check($sformatf("tbl%0d n_valid", v), got_q.size(), 1);
            if (got_q.size() >= 1) begin
                check($sformatf("tbl%0d g", v), got_q[0][39:32], tbl[v].eg);
                check($sformatf("tbl%0d r", v), got_q[0][31:24], tbl[v].er);
                check($sformatf("tbl%0d b", v), got_q[0][23:16], tbl[v].eb);
                check($sformatf("tbl%0d led", v), got_q[0][15:0], 0);
            end
            check($sformatf("tbl%0d latency", v), last_lat, 3);
            check($sformatf("tbl%0d done", v), done_cnt, 1);
            check($sformatf("tbl%0d err", v), bus.oERR, 0);
        end

        clear_frame();
        add_bits(24'h123456, 24, T0H, T1H);
        add_bits(24'hABCDEF, 24, T0H, T1H);
        add_bits(24'h00FF00, 24, T0H, T1H);
        play(RST_LO);
        check_frame("three px");

        clear_frame();
        add_bits(24'hF0F000, 12, T0H, T1H);
        play(RST_LO);
        check_frame("partial");
        check("partial err set", bus.oERR, 1);
        clear_frame();
        add_bits(24'h3C3C3C, 24, T0H, T1H);
        play(RST_LO);
        check_frame("after partial");

        clear_frame();
        add_bits(24'h5A0000, 10, T0H, T1H);
        hi_q.push_back(80);
        lo_q.push_back(20);
        add_bits(24'h123456, 24, T0H, T1H);
        play(SYNC_LO);
        check("overlong n_valid", got_q.size(), 0);
        check("overlong done", done_cnt, 0);
        check("overlong err", bus.oERR, 1);
        clear_frame();
        add_bits(24'h777777, 24, T0H, T1H);
        play(RST_LO);
        check_frame("after overlong");

        clear_frame();
        add_bits(24'hA5C33C, 24, THRESH - 1, THRESH);
        play(RST_LO);
        check_frame("thresh");
        if (got_q.size() >= 1) check("thresh px", got_q[0][39:16], 24'hA5C33C);

        clear_frame();
        add_bits(24'hA5A5A5, 8, T0H, T1H);
        lo_q[7] = 10;
        hi_q.push_back(2);
        lo_q.push_back(TBIT - hi_q[7] - 12);
        add_bits(24'hA5A500, 16, T0H, T1H);
        play(RST_LO);
        check_frame("spike");
        if (got_q.size() >= 1) check("spike px", got_q[0][39:16], SPIKE_PX);

        for (int f = 0; f < 4; f++) begin
            clear_frame();
            nbits = int'($urandom_range(1, 3)) * 24 + ((f == 3) ? 7 : 0);
            for (int k = 0; k < nbits; k++) begin
                bv = int'($urandom_range(0, 1));
                h  = (bv != 0) ? int'($urandom_range(THRESH, MAX_HIGH))
                               : int'($urandom_range(MIN_HIGH, THRESH - 1));
                hi_q.push_back(h);
                lo_q.push_back(int'($urandom_range(8, 40)));
            end
            play(RST_LO);
            check_frame($sformatf("rand%0d", f));
        end

        clear_frame();
        add_bits(24'hFFFF00, 10, T0H, T1H);
        play(5);
        drive(1'b1, 10);
        rst_n = 1'b0;
        #1;
        check("midrst r", bus.r, 0);
        check("midrst g", bus.g, 0);
        check("midrst b", bus.b, 0);
        check("midrst led", bus.oLED, 0);
        check("midrst err", bus.oERR, 0);
        bus.i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_frame();
        add_bits(24'hC0FFEE, 24, T0H, T1H);
        play(RST_LO);
        check("post-rst sync n_valid", got_q.size(), 0);
        check("post-rst sync done", done_cnt, 0);
        clear_frame();
        add_bits(24'h102030, 24, T0H, T1H);
        play(RST_LO);
        check_frame("post-rst frame");

        check("valid/done overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
